prog_sequencer: RTL and testbench

- Host-side controller for the program counter's init/halt handshake.
- Runs the resident programs in order, 0 to NUM_PROGS-1. For each program it drives prog_state, pulses init, and waits for halt.
- Measures execution cycles per program and flags programs that never halt.
- Sits between the testbench/top level and the processor core; replaces hand-sequenced init/prog_state stimulus.

---
 rtl/prog_sequencer.sv | 85 ++++++++
 tb/tb_prog_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs programs 0..NUM_PROGS-1 through the PC init/halt handshake and times each one
//   CLK, reset (async, active-high)
//   start        : begin a full sequence (honoured only in IDLE/DONE)
//   halt         : halt flag from the program counter (honoured only in RUN)
//   init         : high for INIT_CYCLES cycles per program
//   prog_state   : index of the program being run
//   busy / done  : sequence in progress / sequence finished
//   cycles       : RUN-cycle count of the last finished program, with one-cycle cycles_valid pulse
//   timeout_err  : sticky flag, set when any program fails to halt within TIMEOUT cycles
module prog_sequencer #(
    parameter int NUM_PROGS   = 3,
    parameter int INIT_CYCLES = 2,
    parameter int TIMEOUT     = 20000,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    output logic             init,
    output logic [1:0]       prog_state,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles,
    output logic             cycles_valid,
    output logic             timeout_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);
    localparam logic [1:0]       LAST_PROG = 2'(NUM_PROGS - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;

    assign init = state == S_INIT;
    assign busy = state == S_INIT || state == S_RUN || state == S_NEXT;
    assign done = state == S_DONE;

    // cnt counts init cycles in INIT and execution cycles in RUN; it is zeroed on every entry to either
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            prog_state   <= 2'd0;
            cnt          <= '0;
            cycles       <= '0;
            cycles_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            cycles_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state       <= S_INIT;
                    prog_state  <= 2'd0;
                    timeout_err <= 1'b0;
                    cnt         <= '0;
                end
                S_INIT: if (cnt == INIT_LAST) begin
                    state <= S_RUN;
                    cnt   <= '0;
                end else cnt <= cnt + CNT_W'(1);
                // halt takes priority over a coincident timeout, so no error in that case
                S_RUN: if (halt || cnt == TO_VAL) begin
                    cycles       <= cnt;
                    cycles_valid <= 1'b1;
                    timeout_err  <= timeout_err | ~halt;
                    state        <= S_NEXT;
                end else cnt <= cnt + CNT_W'(1);
                S_NEXT: begin
                    cnt <= '0;
                    if (prog_state == LAST_PROG) state <= S_DONE;
                    else begin
                        prog_state <= prog_state + 2'd1;
                        state      <= S_INIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: scoreboard bench for prog_sequencer (3-program and 1-program configurations)
module tb_prog_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0, halt_a = 1'b0, start_b = 1'b0, halt_b = 1'b0;
    logic        init_a, busy_a, done_a, cv_a, err_a;
    logic        init_b, busy_b, done_b, cv_b, err_b;
    logic [1:0]  ps_a, ps_b;
    logic [15:0] cyc_a, cyc_b;
    int          n_cmp = 0, n_err = 0;
    int          exp_c[$], exp_p[$];
    int          ilen = 0;
    logic        prev_cv = 1'b0;

    prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .TIMEOUT(10), .CNT_W(16)) dut_a (
        .CLK(clk), .reset(reset), .start(start_a), .halt(halt_a), .init(init_a),
        .prog_state(ps_a), .busy(busy_a), .done(done_a), .cycles(cyc_a),
        .cycles_valid(cv_a), .timeout_err(err_a));

    prog_sequencer #(.NUM_PROGS(1), .INIT_CYCLES(1), .TIMEOUT(10), .CNT_W(16)) dut_b (
        .CLK(clk), .reset(reset), .start(start_b), .halt(halt_b), .init(init_b),
        .prog_state(ps_b), .busy(busy_b), .done(done_b), .cycles(cyc_b),
        .cycles_valid(cv_b), .timeout_err(err_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every cycles_valid and checks the init pulse width
    always @(negedge clk) begin
        if (reset) begin
            ilen = 0;
            prev_cv = 1'b0;
        end else begin
            if (cv_a) begin
                chk("cv_double", int'(prev_cv), 0);
                if (exp_c.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got cycles=%0d with nothing expected", cyc_a);
                end else begin
                    chk("sb_cycles", int'(cyc_a), exp_c.pop_front());
                    chk("sb_prog", int'(ps_a), exp_p.pop_front());
                end
            end
            prev_cv = cv_a;
            if (init_a) ilen++;
            else if (ilen > 0) begin
                chk("init_len", ilen, 2);
                ilen = 0;
            end
        end
    end

    task automatic pulse_start();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    // acts as the program counter for one program: k<0 never halts, glitch holds halt high outside RUN
    task automatic drive_prog(input int k, input bit glitch, input bit poke, input int idx);
        int b = 0;
        while (!init_a && b < 200) begin @(negedge clk); b++; end
        while (init_a && b < 200) begin @(negedge clk); b++; end
        chk("wait_run", int'(b >= 200), 0);
        halt_a = 1'b0;
        if (k >= 0) begin
            if (poke) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                chk("poke_init", int'(init_a), 0);
                chk("poke_prog", int'(ps_a), idx);
                repeat (k - 1) @(negedge clk);
            end else repeat (k) @(negedge clk);
            halt_a = 1'b1;
            @(negedge clk);
            halt_a = glitch;
        end
    endtask

    task automatic run_seq(input int k0, input int k1, input int k2, input bit glitch,
                           input int poke_idx, input bit exp_err);
        int ks[3] = '{k0, k1, k2};
        int b = 0;
        for (int i = 0; i < 3; i++) begin
            exp_p.push_back(i);
            exp_c.push_back((ks[i] < 0 || ks[i] > 10) ? 10 : ks[i]);
        end
        halt_a = glitch;
        pulse_start();
        chk("start_init", int'(init_a), 1);
        chk("start_prog", int'(ps_a), 0);
        chk("start_done", int'(done_a), 0);
        chk("start_err", int'(err_a), 0);
        for (int i = 0; i < 3; i++) drive_prog(ks[i], glitch, i == poke_idx, i);
        while (!done_a && b < 50) begin @(negedge clk); b++; end
        halt_a = 1'b0;
        chk("end_done", int'(done_a), 1);
        chk("end_busy", int'(busy_a), 0);
        chk("end_prog", int'(ps_a), 2);
        chk("end_err", int'(err_a), int'(exp_err));
    endtask

    initial begin
        #1;
        chk("rst_init", int'(init_a), 0);
        chk("rst_prog", int'(ps_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_cycles", int'(cyc_a), 0);
        chk("rst_cv", int'(cv_a), 0);
        chk("rst_err", int'(err_a), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq(5, 7, 9, 1'b0, -1, 1'b0);
        run_seq(4, -1, 3, 1'b0, -1, 1'b1);
        repeat (5) @(negedge clk);
        chk("err_sticky", int'(err_a), 1);
        run_seq(10, 2, 6, 1'b1, -1, 1'b0);
        run_seq(3, 6, 4, 1'b0, 1, 1'b0);
        exp_p.push_back(0);
        exp_c.push_back(3);
        pulse_start();
        drive_prog(3, 1'b0, 1'b0, 0);
        drive_prog(-1, 1'b0, 1'b0, 1);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_init", int'(init_a), 0);
        chk("arst_prog", int'(ps_a), 0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_done", int'(done_a), 0);
        chk("arst_cycles", int'(cyc_a), 0);
        chk("arst_cv", int'(cv_a), 0);
        chk("arst_err", int'(err_a), 0);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_sb_empty", exp_c.size(), 0);
        repeat (3) @(negedge clk);
        run_seq(2, 3, 4, 1'b0, -1, 1'b0);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_init_on", int'(init_b), 1);
        @(negedge clk);
        chk("b_init_off", int'(init_b), 0);
        chk("b_busy", int'(busy_b), 1);
        repeat (2) @(negedge clk);
        halt_b = 1'b1;
        @(negedge clk);
        halt_b = 1'b0;
        chk("b_cv", int'(cv_b), 1);
        chk("b_cycles", int'(cyc_b), 2);
        @(negedge clk);
        chk("b_cv_drop", int'(cv_b), 0);
        chk("b_done", int'(done_b), 1);
        chk("b_busy_end", int'(busy_b), 0);
        chk("b_prog", int'(ps_b), 0);
        chk("b_err", int'(err_b), 0);
        repeat (2) @(negedge clk);
        chk("sb_drain", exp_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end
endmodule
